next_line_prefetch_unit: RTL and testbench
==========================================

// Module: next_line_prefetch_unit
// PURPOSE
// - Next-line hardware prefetcher feeding the prefetch-capable cache control.
// - Watches demand misses via prefetch_start and computes line address A+LINE_BYTES.
// - After the demand fill finishes, fetches that line from physical memory through its own pmem port.
// - Buffers the line and raises prefetch_ready until the cache installs it into pf_cache_way.
// - Sits upstream of the cache control/datapath and downstream of the pmem arbiter.
// PARAMETERS
// ADDR_W      32   byte address width
// LINE_W      256  cacheline width in bits
// OFFSET_W    5    line offset bits (LINE_BYTES = 2**OFFSET_W)
// CNT_W       16   width of prefetch statistics counter
// PORTS
// clk             in   1         clock, all state updates on posedge
// rst             in   1         reset, asynchronous, active-low (0 = reset)
// prefetch_start  in   1         cache is in demand-read state (high for whole fill)
// demand_addr     in   ADDR_W    address of the demand miss, valid while prefetch_start=1
// pf_pmem_read    out  1         read request to pmem arbiter
// pf_pmem_addr    out  ADDR_W    line-aligned prefetch address
// pf_pmem_resp    in   1         1-cycle response; pf_pmem_rdata valid this cycle
// pf_pmem_rdata   in   LINE_W    fetched line
// pf_present      in   1         cache tag hit (either way) for pf_addr's set/tag
// pf_lru          in   1         LRU bit of pf_addr's set
// prefetch_ready  out  1         buffered line ready for install
// pf_ack          in   1         cache is in prefetch (install) state this cycle
// pf_addr         out  ADDR_W    address of buffered line (to cache tag/index mux)
// pf_line         out  LINE_W    buffered line data (cache data_in_sel=2'b11)
// pf_cache_way    out  1         way to install into (= pf_lru sampled in CHECK)
// pf_count        out  CNT_W     number of lines installed, saturating
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE. All outputs 0: pf_pmem_read, prefetch_ready,
//   pf_addr, pf_line, pf_cache_way, pf_count.
// - pf_pmem_addr = pf_addr in all states. pf_addr is always line-aligned; offset bits are 0.
// - FSM states and transitions:
//   IDLE:  if prefetch_start=1, latch pf_addr = {demand_addr[ADDR_W-1:OFFSET_W]+1, 0}.
//          Then go to WAIT_DEMAND.
//          If demand_addr is in the last line of the address space (the +1 wraps to 0),
//          do not prefetch; stay in IDLE.
//   WAIT_DEMAND: stay in this state while prefetch_start=1.
//          On the first cycle prefetch_start=0 (demand fill done), go to ISSUE.
//   ISSUE: pf_pmem_read=1, held until pf_pmem_resp.
//          On pf_pmem_resp: pf_line <= pf_pmem_rdata, then go to CHECK.
//          pf_pmem_addr must stay stable while pf_pmem_read=1.
//   CHECK: one cycle. If pf_present=1, go to IDLE (line already cached; prefetch_ready never rises).
//          Otherwise pf_cache_way <= pf_lru, then go to READY.
//   READY: prefetch_ready=1, held until pf_ack=1.
//          On pf_ack, go to IDLE and increment pf_count (saturating at all-ones).
//          prefetch_ready drops the cycle after pf_ack.
// - Only one prefetch is outstanding at a time. prefetch_start is sampled only in IDLE
//   and ignored in all other states.
// - Latency: pf_pmem_read rises 1 cycle after prefetch_start falls.
//   prefetch_ready rises 2 cycles after pf_pmem_resp (capture cycle, then CHECK).
// - pf_line, pf_addr and pf_cache_way must stay stable while prefetch_ready=1.
// - pf_pmem_resp outside ISSUE is ignored. pf_ack outside READY is ignored.
// - Reset mid-operation (any state): outputs clear immediately and pf_pmem_read drops.
//   A late pmem response after reset is ignored because state is IDLE.
// - pf_count does not wrap: it saturates at 2**CNT_W-1.
// TESTING
// - Basic fetch:
//   stimulus: prefetch_start=1 for 10 cycles, demand_addr=0x0000_1234; then drop it;
//             pmem resp after 5 cycles with data D.
//   required: pf_pmem_addr=0x0000_1240; prefetch_ready rises 2 cycles after resp;
//             pf_line=D; pf_ack -> pf_count=1.
// - Already present:
//   stimulus: same sequence as Basic fetch, with pf_present=1 in CHECK.
//   required: prefetch_ready stays 0; FSM returns to IDLE; pf_count unchanged.
// - Way select:
//   stimulus: pf_lru=1 in CHECK, then pf_lru toggles during READY.
//   required: pf_cache_way stays 1 until pf_ack.
// - Top-of-memory:
//   stimulus: demand_addr=0xFFFF_FFE4.
//   required: pf_pmem_read never asserts; FSM stays in IDLE.
// - Ignore while busy:
//   stimulus: second prefetch_start pulse with demand_addr=0x2000 during READY.
//   required: pf_addr stays 0x1240; no second pmem read until after pf_ack.
// - Async reset mid-ISSUE:
//   stimulus: rst=0 while pf_pmem_read=1; then pf_pmem_resp=1 after reset is released.
//   required: all outputs 0 with no clock edge; the response is ignored; FSM is in IDLE.

Source files
------------

// File: rtl/next_line_prefetch_unit.sv
// Next-line prefetcher: on a demand miss it fetches the following cache line
// and buffers it until the cache control installs it.
module next_line_prefetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prefetch_start,
  input  logic [ADDR_W-1:0] demand_addr,
  output logic              pf_pmem_read,
  output logic [ADDR_W-1:0] pf_pmem_addr,
  input  logic              pf_pmem_resp,
  input  logic [LINE_W-1:0] pf_pmem_rdata,
  input  logic              pf_present,
  input  logic              pf_lru,
  output logic              prefetch_ready,
  input  logic              pf_ack,
  output logic [ADDR_W-1:0] pf_addr,
  output logic [LINE_W-1:0] pf_line,
  output logic              pf_cache_way,
  output logic [CNT_W-1:0]  pf_count
);

  localparam int IDX_W = ADDR_W - OFFSET_W;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] WAIT_DEMAND = 3'd1;
  localparam logic [2:0] ISSUE       = 3'd2;
  localparam logic [2:0] CHECK       = 3'd3;
  localparam logic [2:0] READY       = 3'd4;

  logic [2:0]     state;
  logic [IDX_W:0] next_idx;

  // The extra top bit is the carry that flags a wrap past the last line.
  assign next_idx = {1'b0, demand_addr[ADDR_W-1:OFFSET_W]} + (IDX_W+1)'(1);

  assign pf_pmem_read   = (state == ISSUE);
  assign prefetch_ready = (state == READY);
  assign pf_pmem_addr   = pf_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pf_addr      <= '0;
      pf_line      <= '0;
      pf_cache_way <= 1'b0;
      pf_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (prefetch_start && !next_idx[IDX_W]) begin
            pf_addr <= {next_idx[IDX_W-1:0], {OFFSET_W{1'b0}}};
            state   <= WAIT_DEMAND;
          end
        end
        WAIT_DEMAND: begin
          if (!prefetch_start) state <= ISSUE;
        end
        ISSUE: begin
          if (pf_pmem_resp) begin
            pf_line <= pf_pmem_rdata;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (pf_present) begin
            state <= IDLE;
          end else begin
            pf_cache_way <= pf_lru;
            state        <= READY;
          end
        end
        READY: begin
          if (pf_ack) begin
            if (pf_count != '1) pf_count <= pf_count + CNT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_next_line_prefetch_unit.sv
// Directed testbench for next_line_prefetch_unit with hand-computed expectations.
module tb_next_line_prefetch_unit;

  logic         clk;
  logic         rst;
  logic         prefetch_start;
  logic [31:0]  demand_addr;
  logic         pf_pmem_read;
  logic [31:0]  pf_pmem_addr;
  logic         pf_pmem_resp;
  logic [255:0] pf_pmem_rdata;
  logic         pf_present;
  logic         pf_lru;
  logic         prefetch_ready;
  logic         pf_ack;
  logic [31:0]  pf_addr;
  logic [255:0] pf_line;
  logic         pf_cache_way;
  logic [15:0]  pf_count;

  int checks;
  int fails;

  localparam logic [255:0] DATA_A = {8{32'hCAFE_F00D}};
  localparam logic [255:0] DATA_B = {8{32'h1357_9BDF}};
  localparam logic [255:0] DATA_C = {8{32'hBAD0_BAD0}};

  next_line_prefetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .prefetch_start (prefetch_start),
    .demand_addr    (demand_addr),
    .pf_pmem_read   (pf_pmem_read),
    .pf_pmem_addr   (pf_pmem_addr),
    .pf_pmem_resp   (pf_pmem_resp),
    .pf_pmem_rdata  (pf_pmem_rdata),
    .pf_present     (pf_present),
    .pf_lru         (pf_lru),
    .prefetch_ready (prefetch_ready),
    .pf_ack         (pf_ack),
    .pf_addr        (pf_addr),
    .pf_line        (pf_line),
    .pf_cache_way   (pf_cache_way),
    .pf_count       (pf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges, landing 1ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    fails          = 0;
    rst            = 1'b0;
    prefetch_start = 1'b0;
    demand_addr    = '0;
    pf_pmem_resp   = 1'b0;
    pf_pmem_rdata  = '0;
    pf_present     = 1'b0;
    pf_lru         = 1'b0;
    pf_ack         = 1'b0;

    tick(2);
    checkOutput("reset_read",  pf_pmem_read, 0);
    checkOutput("reset_ready", prefetch_ready, 0);
    checkOutput("reset_addr",  pf_addr, 0);
    checkOutput("reset_line",  pf_line, 0);
    checkOutput("reset_way",   pf_cache_way, 0);
    checkOutput("reset_count", pf_count, 0);
    rst = 1'b1;
    tick(1);

    // Basic fetch
    prefetch_start = 1'b1;
    demand_addr    = 32'h0000_1234;
    tick(1);
    checkOutput("basic_addr_latched", pf_addr, 32'h0000_1240);
    checkOutput("basic_no_read_during_demand", pf_pmem_read, 0);
    tick(9);
    prefetch_start = 1'b0;
    tick(1);
    checkOutput("basic_read_rise", pf_pmem_read, 1);
    checkOutput("basic_pmem_addr", pf_pmem_addr, 32'h0000_1240);
    tick(4);
    checkOutput("basic_read_held", pf_pmem_read, 1);
    checkOutput("basic_pmem_addr_stable", pf_pmem_addr, 32'h0000_1240);
    pf_pmem_resp  = 1'b1;
    pf_pmem_rdata = DATA_A;
    tick(1);
    pf_pmem_resp  = 1'b0;
    pf_pmem_rdata = '0;
    checkOutput("basic_check_read_low", pf_pmem_read, 0);
    checkOutput("basic_check_not_ready", prefetch_ready, 0);
    tick(1);
    checkOutput("basic_ready_rise", prefetch_ready, 1);
    checkOutput("basic_line", pf_line, DATA_A);
    checkOutput("basic_way", pf_cache_way, 0);
    checkOutput("basic_count_before_ack", pf_count, 0);
    pf_ack = 1'b1;
    tick(1);
    pf_ack = 1'b0;
    checkOutput("basic_ready_drop", prefetch_ready, 0);
    checkOutput("basic_count", pf_count, 1);

    // Already present
    prefetch_start = 1'b1;
    demand_addr    = 32'h0000_1234;
    tick(2);
    prefetch_start = 1'b0;
    tick(1);
    checkOutput("present_read", pf_pmem_read, 1);
    pf_pmem_resp  = 1'b1;
    pf_pmem_rdata = DATA_B;
    pf_present    = 1'b1;
    tick(1);
    pf_pmem_resp = 1'b0;
    tick(1);
    pf_present = 1'b0;
    checkOutput("present_no_ready", prefetch_ready, 0);
    tick(2);
    checkOutput("present_still_no_ready", prefetch_ready, 0);
    checkOutput("present_read_idle", pf_pmem_read, 0);
    checkOutput("present_count", pf_count, 1);

    // Way select, plus a second request while busy
    prefetch_start = 1'b1;
    demand_addr    = 32'h0000_1234;
    tick(1);
    prefetch_start = 1'b0;
    tick(1);
    checkOutput("way_read", pf_pmem_read, 1);
    pf_pmem_resp  = 1'b1;
    pf_pmem_rdata = DATA_B;
    pf_lru        = 1'b1;
    tick(1);
    pf_pmem_resp = 1'b0;
    tick(1);
    checkOutput("way_ready", prefetch_ready, 1);
    checkOutput("way_sampled", pf_cache_way, 1);
    pf_lru         = 1'b0;
    prefetch_start = 1'b1;
    demand_addr    = 32'h0000_2000;
    tick(1);
    prefetch_start = 1'b0;
    checkOutput("way_held_lru0", pf_cache_way, 1);
    checkOutput("busy_addr_held", pf_addr, 32'h0000_1240);
    checkOutput("busy_no_read", pf_pmem_read, 0);
    checkOutput("busy_line_held", pf_line, DATA_B);
    pf_lru = 1'b1;
    tick(1);
    pf_lru = 1'b0;
    tick(1);
    checkOutput("way_held_toggle", pf_cache_way, 1);
    checkOutput("busy_still_ready", prefetch_ready, 1);
    pf_ack = 1'b1;
    tick(1);
    pf_ack = 1'b0;
    checkOutput("way_ack_ready_drop", prefetch_ready, 0);
    checkOutput("way_count", pf_count, 2);
    tick(2);
    checkOutput("busy_no_second_read", pf_pmem_read, 0);
    checkOutput("busy_addr_after", pf_addr, 32'h0000_1240);

    // Top of memory
    prefetch_start = 1'b1;
    demand_addr    = 32'hFFFF_FFE4;
    tick(3);
    prefetch_start = 1'b0;
    checkOutput("top_no_read_during", pf_pmem_read, 0);
    tick(3);
    checkOutput("top_no_read_after", pf_pmem_read, 0);
    checkOutput("top_addr_unchanged", pf_addr, 32'h0000_1240);

    // Async reset mid-ISSUE
    prefetch_start = 1'b1;
    demand_addr    = 32'h0000_1234;
    tick(1);
    prefetch_start = 1'b0;
    tick(1);
    checkOutput("rst_pre_read", pf_pmem_read, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_read", pf_pmem_read, 0);
    checkOutput("rst_ready", prefetch_ready, 0);
    checkOutput("rst_addr", pf_addr, 0);
    checkOutput("rst_pmem_addr", pf_pmem_addr, 0);
    checkOutput("rst_line", pf_line, 0);
    checkOutput("rst_way", pf_cache_way, 0);
    checkOutput("rst_count", pf_count, 0);
    tick(1);
    rst           = 1'b1;
    pf_pmem_resp  = 1'b1;
    pf_pmem_rdata = DATA_C;
    tick(1);
    pf_pmem_resp  = 1'b0;
    pf_pmem_rdata = '0;
    checkOutput("late_resp_read", pf_pmem_read, 0);
    checkOutput("late_resp_line", pf_line, 0);
    tick(1);
    checkOutput("late_resp_ready", prefetch_ready, 0);
    prefetch_start = 1'b1;
    demand_addr    = 32'h0000_0040;
    tick(1);
    prefetch_start = 1'b0;
    checkOutput("post_rst_idle_latch", pf_addr, 32'h0000_0060);
    tick(1);
    checkOutput("post_rst_read", pf_pmem_read, 1);
    checkOutput("post_rst_pmem_addr", pf_pmem_addr, 32'h0000_0060);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
